// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM bus arbiter.
//  sram_state_t : bus sequencer states (idle, strobe active, turnaround)
//  sram_req_t   : requester identifiers, also used as bit index into request vectors
//  req_onehot() : maps a requester id onto its bit in a request vector
package sram_arbiter_pkg;

  typedef enum logic [1:0] {SRAM_IDLE, SRAM_ACC, SRAM_TURN} sram_state_t;
  typedef enum logic [1:0] {REQ_VID, REQ_INI, REQ_CPU, REQ_DMA} sram_req_t;

  localparam int NUM_REQ = 4;
  // Width of the strobe-length counter; holds ACCESS_CYCLES-1 for ACCESS_CYCLES in 1..7.
  localparam int CNT_W   = 3;

  function automatic logic [NUM_REQ-1:0] req_onehot(input sram_req_t id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant selection for the SRAM arbiter.
//  req_i         in  4  pending requests, bit index = sram_req_t
//  init_active_i in  1  initializer owns memory: CPU and DMA are not eligible
//  rr_i          in  2  round-robin pointer, names CPU or DMA as the favoured one
//  grant_valid_o out 1  some requester is eligible
//  grant_id_o    out 2  the requester to grant
// Priority: video > initializer > {CPU, DMA}; CPU and DMA tie-break via rr_i.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               init_active_i,
  input  sram_req_t          rr_i,
  output logic               grant_valid_o,
  output sram_req_t          grant_id_o
);

  logic cpu_ok;
  logic dma_ok;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a value held (which would infer a latch).
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = REQ_VID;
    cpu_ok        = req_i[REQ_CPU] && !init_active_i;
    dma_ok        = req_i[REQ_DMA] && !init_active_i;

    if (req_i[REQ_VID]) begin
      grant_valid_o = 1'b1;
      grant_id_o    = REQ_VID;
    end else if (req_i[REQ_INI]) begin
      grant_valid_o = 1'b1;
      grant_id_o    = REQ_INI;
    end else if (cpu_ok && dma_ok) begin
      grant_valid_o = 1'b1;
      grant_id_o    = (rr_i == REQ_DMA) ? REQ_DMA : REQ_CPU;
    end else if (cpu_ok) begin
      grant_valid_o = 1'b1;
      grant_id_o    = REQ_CPU;
    end else if (dma_ok) begin
      grant_valid_o = 1'b1;
      grant_id_o    = REQ_DMA;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Schedules the single external SRAM bus among video fetch, ROM initializer,
// CPU and DMA. One access at a time: IDLE -> ACC (ACCESS_CYCLES) -> TURN (1)
// -> IDLE or straight into the next ACC.
//  clk28, rst (async, active-high)
//  init_active                 holds off CPU/DMA while the initializer owns memory
//  {vid,ini,cpu,dma}_req/_wr/_addr/_wdata   level requests, address/data sampled at grant
//  {vid,ini,cpu,dma}_done      one-cycle pulse during TURN of the owner's access
//  rdata                       read data, valid while a _done pulses
//  va, vd_in, vd_out, vd_oe    SRAM address and data pads
//  n_vrd, n_vwr                active-low strobes
//  busy                        sequencer not idle
// ACCESS_CYCLES must lie in 1..7 (3-bit reloaded counter).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW            = 19,
  parameter int DW            = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          clk28,
  input  logic          rst,
  input  logic          init_active,
  input  logic          vid_req,
  input  logic          vid_wr,
  input  logic [AW-1:0] vid_addr,
  input  logic [DW-1:0] vid_wdata,
  output logic          vid_done,
  input  logic          ini_req,
  input  logic          ini_wr,
  input  logic [AW-1:0] ini_addr,
  input  logic [DW-1:0] ini_wdata,
  output logic          ini_done,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] va,
  input  logic [DW-1:0] vd_in,
  output logic [DW-1:0] vd_out,
  output logic          vd_oe,
  output logic          n_vrd,
  output logic          n_vwr,
  output logic          busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  sram_state_t       state_q, state_d;
  sram_req_t         owner_q, owner_d;
  sram_req_t         rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     va_q, va_d;
  logic [DW-1:0]     vd_out_q, vd_out_d;
  logic              vd_oe_q, vd_oe_d;
  logic              n_vrd_q, n_vrd_d;
  logic              n_vwr_q, n_vwr_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] arb_req;
  logic               grant_valid;
  sram_req_t          grant_id;
  logic               grant;
  logic               sel_wr;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  assign req_vec = {dma_req, cpu_req, ini_req, vid_req};

  // During TURN the finishing owner still holds its request (it only sees
  // _done now), so it is masked out to avoid serving the same request twice.
  always_comb begin
    arb_req = req_vec;
    if (state_q == SRAM_TURN) begin
      arb_req = req_vec & ~req_onehot(owner_q);
    end
  end

  sram_arb_pick u_pick (
    .req_i         (arb_req),
    .init_active_i (init_active),
    .rr_i          (rr_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Arbitration happens in IDLE and TURN, never while strobes are active.
  assign grant = (state_q != SRAM_ACC) && grant_valid;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (grant_id)
      REQ_VID: begin sel_wr = vid_wr; sel_addr = vid_addr; sel_wdata = vid_wdata; end
      REQ_INI: begin sel_wr = ini_wr; sel_addr = ini_addr; sel_wdata = ini_wdata; end
      REQ_CPU: begin sel_wr = cpu_wr; sel_addr = cpu_addr; sel_wdata = cpu_wdata; end
      REQ_DMA: begin sel_wr = dma_wr; sel_addr = dma_addr; sel_wdata = dma_wdata; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    va_d     = va_q;
    vd_out_d = vd_out_q;
    vd_oe_d  = vd_oe_q;
    n_vrd_d  = n_vrd_q;
    n_vwr_d  = n_vwr_q;
    rdata_d  = rdata_q;

    case (state_q)
      SRAM_IDLE, SRAM_TURN: begin
        if (grant) begin
          state_d  = SRAM_ACC;
          owner_d  = grant_id;
          cnt_d    = CNT_LOAD;
          va_d     = sel_addr;
          vd_out_d = sel_wdata;
          // Write->write keeps vd_oe high across TURN; write->read drops it
          // together with n_vrd falling, so the pads never fight the SRAM.
          vd_oe_d  = sel_wr;
          n_vrd_d  = sel_wr;
          n_vwr_d  = ~sel_wr;
          if (grant_id == REQ_CPU || grant_id == REQ_DMA) begin
            rr_d = (grant_id == REQ_CPU) ? REQ_DMA : REQ_CPU;
          end
        end else begin
          state_d = SRAM_IDLE;
          vd_oe_d = 1'b0;
        end
      end
      SRAM_ACC: begin
        if (cnt_q == '0) begin
          state_d = SRAM_TURN;
          n_vrd_d = 1'b1;
          n_vwr_d = 1'b1;
          if (!n_vrd_q) begin
            rdata_d = vd_in;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = SRAM_IDLE;
        n_vrd_d = 1'b1;
        n_vwr_d = 1'b1;
        vd_oe_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q  <= SRAM_IDLE;
      owner_q  <= REQ_VID;
      rr_q     <= REQ_CPU;
      cnt_q    <= '0;
      va_q     <= '0;
      vd_out_q <= '0;
      vd_oe_q  <= 1'b0;
      n_vrd_q  <= 1'b1;
      n_vwr_q  <= 1'b1;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      va_q     <= va_d;
      vd_out_q <= vd_out_d;
      vd_oe_q  <= vd_oe_d;
      n_vrd_q  <= n_vrd_d;
      n_vwr_q  <= n_vwr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign vid_done = (state_q == SRAM_TURN) && (owner_q == REQ_VID);
  assign ini_done = (state_q == SRAM_TURN) && (owner_q == REQ_INI);
  assign cpu_done = (state_q == SRAM_TURN) && (owner_q == REQ_CPU);
  assign dma_done = (state_q == SRAM_TURN) && (owner_q == REQ_DMA);

  assign rdata  = rdata_q;
  assign va     = va_q;
  assign vd_out = vd_out_q;
  assign vd_oe  = vd_oe_q;
  assign n_vrd  = n_vrd_q;
  assign n_vwr  = n_vwr_q;
  assign busy   = (state_q != SRAM_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a rule-level model of the arbitration and strobe timing.
module tb_sram_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int AC = 2;

  logic          clk28 = 1'b0;
  logic          rst = 1'b1;
  logic          init_active = 1'b0;
  logic [3:0]    req = '0;
  logic [3:0]    wr = '0;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wdata [4];
  logic [DW-1:0] vd_in = '0;
  logic          vid_done, ini_done, cpu_done, dma_done;
  logic [DW-1:0] rdata, vd_out;
  logic [AW-1:0] va;
  logic          vd_oe, n_vrd, n_vwr, busy;
  wire  [3:0]    done = {dma_done, cpu_done, ini_done, vid_done};

  int vectors = 0;
  int miscompares = 0;

  always #18 clk28 = ~clk28;

  sram_arbiter #(.AW(AW), .DW(DW), .ACCESS_CYCLES(AC)) dut (
    .clk28(clk28), .rst(rst), .init_active(init_active),
    .vid_req(req[0]), .vid_wr(wr[0]), .vid_addr(addr[0]), .vid_wdata(wdata[0]), .vid_done(vid_done),
    .ini_req(req[1]), .ini_wr(wr[1]), .ini_addr(addr[1]), .ini_wdata(wdata[1]), .ini_done(ini_done),
    .cpu_req(req[2]), .cpu_wr(wr[2]), .cpu_addr(addr[2]), .cpu_wdata(wdata[2]), .cpu_done(cpu_done),
    .dma_req(req[3]), .dma_wr(wr[3]), .dma_addr(addr[3]), .dma_wdata(wdata[3]), .dma_done(dma_done),
    .rdata(rdata), .va(va), .vd_in(vd_in), .vd_out(vd_out), .vd_oe(vd_oe),
    .n_vrd(n_vrd), .n_vwr(n_vwr), .busy(busy)
  );

  // {n_vrd, n_vwr, vd_oe, busy, done[3:0]}
  function automatic logic [7:0] ctl();
    return {n_vrd, n_vwr, vd_oe, busy, done};
  endfunction

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0;
    wr = '0;
    for (int k = 0; k < 4; k++) begin
      addr[k] = '0;
      wdata[k] = '0;
    end
    vd_in = '0;
    init_active = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    vectors++;
    if (ctl() !== 8'b1100_0000) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 11000000", ctl());
    end
    vectors++;
    if (va !== '0) begin miscompares++; $display("FAIL reset_va: got %h want 0", va); end
    vectors++;
    if (vd_out !== '0) begin miscompares++; $display("FAIL reset_vd_out: got %h want 0", vd_out); end
    vectors++;
    if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    logic [7:0] exp_ctl [4];
    exp_ctl = '{8'b0101_0000, 8'b0101_0000, 8'b1101_0100, 8'b1100_0000};
    do_reset();
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 19'h12345;
    for (int c = 1; c <= 4; c++) begin
      tick();
      vd_in = (c == 1) ? 8'h00 : (c == 2) ? 8'hA5 : 8'hFF;
      if (c == 4) req[2] = 1'b0;
      vectors++;
      if (ctl() !== exp_ctl[c-1]) begin
        miscompares++; $display("FAIL read_ctl c%0d: got %b want %b", c, ctl(), exp_ctl[c-1]);
      end
      if (c <= 3) begin
        vectors++;
        if (va !== 19'h12345) begin miscompares++; $display("FAIL read_va c%0d: got %h want 12345", c, va); end
      end
      if (c == 3) begin
        vectors++;
        if (rdata !== 8'hA5) begin miscompares++; $display("FAIL read_rdata: got %h want a5", rdata); end
      end
    end
  endtask

  task automatic test_cpu_write();
    logic [7:0] exp_ctl [4];
    exp_ctl = '{8'b1011_0000, 8'b1011_0000, 8'b1111_0100, 8'b1100_0000};
    do_reset();
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 19'h00010; wdata[2] = 8'h5A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) req[2] = 1'b0;
      vectors++;
      if (ctl() !== exp_ctl[c-1]) begin
        miscompares++; $display("FAIL write_ctl c%0d: got %b want %b", c, ctl(), exp_ctl[c-1]);
      end
      if (c <= 3) begin
        vectors++;
        if (va !== 19'h00010 || vd_out !== 8'h5A) begin
          miscompares++; $display("FAIL write_bus c%0d: got va=%h vd=%h want va=00010 vd=5a", c, va, vd_out);
        end
      end
    end
  endtask

  task automatic test_order();
    int order[$];
    int exp_order [6];
    logic [3:0] done_last;
    exp_order = '{0, 2, 3, 2, 3, 2};
    do_reset();
    req = 4'b1101;
    addr[0] = 19'h40000; addr[2] = 19'h00100; addr[3] = 19'h00200;
    done_last = '0;
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      tick();
      if (done_last[0]) req[0] = 1'b0;
      for (int k = 0; k < 4; k++) if (done[k]) order.push_back(k);
      done_last = done;
    end
    req = '0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= order.size()) begin
        miscompares++; $display("FAIL order[%0d]: got none want %0d", i, exp_order[i]);
      end else if (order[i] != exp_order[i]) begin
        miscompares++; $display("FAIL order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_init_priority();
    int ini_cnt, other_cnt, first;
    do_reset();
    init_active = 1'b1;
    req = 4'b1110;
    ini_cnt = 0; other_cnt = 0; first = -1;
    for (int c = 0; c < 80 && ini_cnt < 3; c++) begin
      tick();
      for (int k = 0; k < 4; k++) if (done[k]) begin
        if (k == 1) ini_cnt++; else other_cnt++;
      end
    end
    vectors++;
    if (ini_cnt != 3) begin miscompares++; $display("FAIL init_ini_grants: got %0d want 3", ini_cnt); end
    vectors++;
    if (other_cnt != 0) begin miscompares++; $display("FAIL init_holdoff: got %0d want 0", other_cnt); end
    tick();
    init_active = 1'b0;
    req[1] = 1'b0;
    for (int c = 0; c < 20 && first < 0; c++) begin
      tick();
      for (int k = 0; k < 4; k++) if (done[k]) first = k;
    end
    vectors++;
    if (first != 2) begin miscompares++; $display("FAIL init_release_first: got %0d want 2", first); end
    req = '0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  task automatic test_reset_mid_write();
    int stray, at, who;
    do_reset();
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 19'h0ABCD; wdata[2] = 8'hC3;
    tick();
    vectors++;
    if (n_vwr !== 1'b0) begin miscompares++; $display("FAIL rstw_inflight: got n_vwr=%b want 0", n_vwr); end
    #5 rst = 1'b1;
    #1;
    vectors++;
    if (ctl() !== 8'b1100_0000 || va !== '0 || vd_out !== '0) begin
      miscompares++; $display("FAIL rstw_async: got ctl=%b va=%h vd=%h want 11000000/0/0", ctl(), va, vd_out);
    end
    req = '0; wr = '0;
    tick();
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done !== 4'b0000) stray++;
    end
    vectors++;
    if (stray != 0) begin miscompares++; $display("FAIL rstw_no_done: got %0d pulses want 0", stray); end
    req[3] = 1'b1; wr[3] = 1'b0; addr[3] = 19'h00777; vd_in = 8'h3C;
    at = -1; who = 4'b0000;
    for (int c = 1; c <= 10 && at < 0; c++) begin
      tick();
      if (done !== 4'b0000) begin at = c; who = done; end
    end
    req = '0;
    vectors++;
    if (at != 3 || who != 4'b1000 || rdata !== 8'h3C) begin
      miscompares++; $display("FAIL rstw_next: got cyc=%0d done=%b rdata=%h want 3/1000/3c", at, who, rdata);
    end
  endtask

  task automatic new_req(input int k);
    req[k] = 1'b1;
    wr[k] = 1'($urandom_range(1));
    addr[k] = {1'b0, 18'($urandom)};
    wdata[k] = 8'($urandom);
  endtask

  task automatic test_random_traffic();
    int m_left, m_owner, m_rr, pick, vid_wait;
    bit m_turn, m_wr, vid_waiting, p_hi, vid_start;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [3:0] p_req, p_wr, eff, done_last;
    logic p_init;
    logic [DW-1:0] p_vd_in;
    logic [AW-1:0] p_addr [4];
    logic [DW-1:0] p_wdata [4];
    logic [7:0] exp_ctl;
    do_reset();
    m_left = 0; m_owner = 0; m_rr = 2; m_turn = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    vid_waiting = 0; vid_wait = 0; p_hi = 1; done_last = '0;
    p_req = req; p_wr = wr; p_addr = addr; p_wdata = wdata; p_init = init_active; p_vd_in = vd_in;
    for (int c = 1; c <= 800; c++) begin
      tick();
      // model: advance one cycle using the inputs that were present before this edge
      if (m_left > 0) begin
        if (m_left == 1 && !m_wr) m_rdata = p_vd_in;
        m_left--;
        m_turn = (m_left == 0);
      end else begin
        eff = p_req;
        if (m_turn) eff[m_owner] = 1'b0;
        if (p_init) eff[3:2] = 2'b00;
        pick = -1;
        if (eff[0]) pick = 0;
        else if (eff[1]) pick = 1;
        else if (eff[2] && eff[3]) pick = m_rr;
        else if (eff[2]) pick = 2;
        else if (eff[3]) pick = 3;
        m_turn = 0;
        if (pick >= 0) begin
          m_owner = pick; m_left = AC; m_wr = p_wr[pick];
          m_addr = p_addr[pick]; m_wdata = p_wdata[pick];
          if (pick >= 2) m_rr = (pick == 2) ? 3 : 2;
        end
      end
      exp_ctl = {(m_left > 0) ? m_wr : 1'b1, (m_left > 0) ? ~m_wr : 1'b1,
                 (m_left > 0 || m_turn) ? m_wr : 1'b0, (m_left > 0 || m_turn),
                 m_turn ? (4'(1) << m_owner) : 4'b0000};
      vectors++;
      if (ctl() !== exp_ctl) begin
        miscompares++; $display("FAIL rand_ctl c%0d: got %b want %b", c, ctl(), exp_ctl);
      end
      if (m_left > 0 || m_turn) begin
        vectors++;
        if (va !== m_addr || (m_wr && vd_out !== m_wdata)) begin
          miscompares++; $display("FAIL rand_bus c%0d: got va=%h vd=%h want va=%h vd=%h", c, va, vd_out, m_addr, m_wdata);
        end
      end
      if (m_turn && !m_wr) begin
        vectors++;
        if (rdata !== m_rdata) begin
          miscompares++; $display("FAIL rand_rdata c%0d: got %h want %h", c, rdata, m_rdata);
        end
      end
      // video wait, measured on the pads: cycles with vid_req high before its strobe falls
      vid_start = !n_vrd && va[AW-1] && p_hi;
      if (vid_waiting) begin
        vid_wait++;
        if (vid_start) begin
          vectors++;
          if (vid_wait > AC + 1) begin
            miscompares++; $display("FAIL vid_wait c%0d: got %0d want <= %0d", c, vid_wait, AC + 1);
          end
          vid_waiting = 0;
        end else if (vid_wait > AC + 1) begin
          vectors++; miscompares++;
          $display("FAIL vid_wait c%0d: got > %0d want <= %0d", c, vid_wait - 1, AC + 1);
          vid_waiting = 0;
        end
      end
      p_hi = n_vrd && n_vwr;
      // requesters: respond to a _done seen last cycle, otherwise request at random
      if (done_last[0]) req[0] = 1'b0;
      if (c % 4 == 0 && !req[0]) begin
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = {1'b1, 18'($urandom)};
        vid_waiting = 1; vid_wait = 0;
      end
      for (int k = 1; k < 4; k++) begin
        if (done_last[k]) begin
          if (k != 1 && $urandom_range(3) != 0) new_req(k); else req[k] = 1'b0;
        end else if (!req[k]) begin
          if (k == 1 ? ($urandom_range(15) == 0) : ($urandom_range(3) == 0)) new_req(k);
        end else if (k != 1 && $urandom_range(31) == 0) begin
          req[k] = 1'b0;
        end
      end
      if (c % 37 == 0) init_active = 1'($urandom_range(1));
      vd_in = 8'($urandom);
      done_last = done;
      p_req = req; p_wr = wr; p_addr = addr; p_wdata = wdata; p_init = init_active; p_vd_in = vd_in;
    end
    clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      addr[k] = '0;
      wdata[k] = '0;
    end
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_order();
    test_init_priority();
    test_reset_mid_write();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
